// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory line controller and the cache-side blocks
// that talk to it.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_RESP = 2'd3
    } mem_state_e;

    localparam int LINE_WORDS = 4;
    localparam int LINE_W     = LINE_WORDS * 32;
    localparam int OFFSET_W   = 2;

endpackage

// File: rtl/mem_line_ctrl.sv
// Cache-line transfer controller: one fill or writeback at a time, fixed access
// latency, then WORDS single-word beats on a single-port bank.
module mem_line_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32,
    parameter int WORDS  = LINE_WORDS,
    parameter int LAT    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [WORDS*DATA_W-1:0]   req_wdata,
    output logic                      resp_valid,
    output logic [WORDS*DATA_W-1:0]   resp_rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_write_en,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int OFF_W = $clog2(WORDS);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] XFER = ST_XFER;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0]              state;
    logic [3:0]              lat_cnt;
    logic [OFF_W-1:0]        beat;
    logic [ADDR_W-1:0]       base;
    logic                    wr_q;
    logic [WORDS*DATA_W-1:0] wdata_q;

    logic accept;
    logic last_beat;
    logic unused_addr_bits;

    assign accept           = (state == IDLE) && req_valid;
    assign last_beat        = (beat == OFF_W'(WORDS - 1));
    assign unused_addr_bits = ^req_addr[OFF_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
            beat    <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    lat_cnt <= 4'(LAT);
                    beat    <= '0;
                    state   <= (LAT == 0) ? XFER : WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) state <= XFER;
                end
                XFER: begin
                    // beat wraps back to 0 on the last beat, ready for the next line
                    beat <= beat + 1'b1;
                    if (last_beat) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base    <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            base    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wr_q    <= req_write;
            wdata_q <= req_wdata;
        end
    end

    // Fill data assembles in place and holds until the next fill overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            resp_rdata <= '0;
        else if (state == XFER && !wr_q)
            resp_rdata[beat*DATA_W +: DATA_W] <= mem_rdata;
    end

    // Bank-side outputs are decoded from state so reset drops the write strobe at once.
    always_comb begin
        mem_addr     = '0;
        mem_write_en = 1'b0;
        mem_wdata    = '0;
        if (state == XFER) begin
            mem_addr     = base | ADDR_W'(beat);
            mem_write_en = wr_q;
            if (wr_q) mem_wdata = wdata_q[beat*DATA_W +: DATA_W];
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);

endmodule
